// File: rtl/vfclass_seq.sv
// Sequential vector fclass: classifies one 64-bit element per cycle and returns RISC-V fclass masks.
// Optional NaN counter output nan_cnt_o enabled by defining VFCLASS_SEQ_NAN_CNT_EN.

package vfclass_seq_pkg;
    typedef struct packed {
        logic        sign;
        logic [10:0] exp;
        logic [51:0] man;
    } fp_t;

    typedef enum logic [2:0] {
        FP_ZERO,
        FP_SUBNORM,
        FP_NORMAL,
        FP_INF,
        FP_QNAN,
        FP_SNAN
    } fp_class_t;
endpackage

// Double-precision category decode; NaNs are labelled by sign only (QNAN for +, SNAN for -).
module classifier_DFP
    import vfclass_seq_pkg::*;
(
    input  fp_t       op_i,
    output fp_class_t cls_c
);
    always_comb begin
        cls_c = FP_NORMAL;
        if (op_i.exp == 11'h000) begin
            cls_c = (op_i.man == 52'd0) ? FP_ZERO : FP_SUBNORM;
        end else if (op_i.exp == 11'h7FF) begin
            if (op_i.man == 52'd0) cls_c = FP_INF;
            else                   cls_c = op_i.sign ? FP_SNAN : FP_QNAN;
        end
    end
endmodule

module vfclass_seq
    import vfclass_seq_pkg::*;
#(
    parameter int unsigned NUM_ELEM = 4,
    parameter int unsigned TAG_W    = 5
) (
    input  logic                               clk_i,
    input  logic                               rstn_i,
    input  logic                               req_valid_i,
    output logic                               req_ready_o,
    input  logic [NUM_ELEM*64-1:0]             req_data_i,
    input  logic [NUM_ELEM-1:0]                req_mask_i,
    input  logic [$clog2(NUM_ELEM):0]          req_vl_i,
    input  logic [TAG_W-1:0]                   req_tag_i,
    output logic                               resp_valid_o,
    input  logic                               resp_ready_i,
    output logic [NUM_ELEM*64-1:0]             resp_data_o,
    output logic [TAG_W-1:0]                   resp_tag_o,
    output logic                               busy_o
`ifdef VFCLASS_SEQ_NAN_CNT_EN
    ,
    output logic [31:0]                        nan_cnt_o
`endif
);
    localparam int unsigned IDX_W = $clog2(NUM_ELEM);
    localparam int unsigned VL_W  = IDX_W + 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t                          state_q, state_d;
    fp_t       [NUM_ELEM-1:0]        data_q, data_d;
    logic      [NUM_ELEM-1:0]        mask_q, mask_d;
    logic      [VL_W-1:0]            vl_q, vl_d;
    logic      [TAG_W-1:0]           tag_q, tag_d;
    logic      [VL_W-1:0]            idx_q, idx_d;
    logic      [NUM_ELEM-1:0][63:0]  res_q, res_d;
    logic                            ready_q, ready_d;
    logic                            valid_q, valid_d;
    logic                            busy_q, busy_d;
`ifdef VFCLASS_SEQ_NAN_CNT_EN
    logic      [31:0]                nan_cnt_q, nan_cnt_d;
`endif

    logic      [IDX_W-1:0]           idx_lo;
    fp_t                             cur_elem;
    fp_class_t                       cur_cls;
    logic      [9:0]                 fclass_c;
    logic                            cur_active;
    logic                            cur_nan;

    assign idx_lo     = idx_q[IDX_W-1:0];
    assign cur_elem   = data_q[idx_lo];
    assign cur_active = (idx_q < vl_q) && mask_q[idx_lo];
    assign cur_nan    = (cur_cls == FP_QNAN) || (cur_cls == FP_SNAN);

    classifier_DFP u_cls (
        .op_i  (cur_elem),
        .cls_c (cur_cls)
    );

    // Map category + sign to the fclass bit; quiet/signalling comes from mantissa bit 51.
    always_comb begin
        fclass_c = 10'd0;
        case (cur_cls)
            FP_INF:     fclass_c[cur_elem.sign ? 0 : 7] = 1'b1;
            FP_NORMAL:  fclass_c[cur_elem.sign ? 1 : 6] = 1'b1;
            FP_SUBNORM: fclass_c[cur_elem.sign ? 2 : 5] = 1'b1;
            FP_ZERO:    fclass_c[cur_elem.sign ? 3 : 4] = 1'b1;
            FP_QNAN,
            FP_SNAN:    fclass_c[cur_elem.man[51] ? 9 : 8] = 1'b1;
            default:    fclass_c = 10'd0;
        endcase
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        mask_d  = mask_q;
        vl_d    = vl_q;
        tag_d   = tag_q;
        idx_d   = idx_q;
        res_d   = res_q;
`ifdef VFCLASS_SEQ_NAN_CNT_EN
        nan_cnt_d = nan_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    data_d  = req_data_i;
                    mask_d  = req_mask_i;
                    vl_d    = (req_vl_i > VL_W'(NUM_ELEM)) ? VL_W'(NUM_ELEM) : req_vl_i;
                    tag_d   = req_tag_i;
                    idx_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                // One extra RUN cycle after the last element keeps latency at NUM_ELEM+1.
                if (idx_q == VL_W'(NUM_ELEM)) begin
                    state_d = S_DONE;
                end else begin
                    res_d[idx_lo] = cur_active ? 64'(fclass_c) : '1;
                    idx_d         = idx_q + VL_W'(1);
`ifdef VFCLASS_SEQ_NAN_CNT_EN
                    if (cur_active && cur_nan && (nan_cnt_q != 32'hFFFF_FFFF))
                        nan_cnt_d = nan_cnt_q + 32'd1;
`endif
                end
            end
            S_DONE: begin
                if (resp_ready_i) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        valid_d = (state_d == S_DONE);
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            data_q  <= '0;
            mask_q  <= '0;
            vl_q    <= '0;
            tag_q   <= '0;
            idx_q   <= '0;
            res_q   <= '0;
            ready_q <= 1'b1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
`ifdef VFCLASS_SEQ_NAN_CNT_EN
            nan_cnt_q <= '0;
`endif
        end else begin
            data_q  <= data_d;
            mask_q  <= mask_d;
            vl_q    <= vl_d;
            tag_q   <= tag_d;
            idx_q   <= idx_d;
            res_q   <= res_d;
            ready_q <= ready_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
`ifdef VFCLASS_SEQ_NAN_CNT_EN
            nan_cnt_q <= nan_cnt_d;
`endif
        end
    end

    assign req_ready_o  = ready_q;
    assign resp_valid_o = valid_q;
    assign busy_o       = busy_q;
    assign resp_data_o  = res_q;
    assign resp_tag_o   = tag_q;
`ifdef VFCLASS_SEQ_NAN_CNT_EN
    assign nan_cnt_o    = nan_cnt_q;
`endif

    logic unused_nan;
    assign unused_nan = cur_nan;

endmodule

// File: tb/tb_vfclass_seq.sv
// Self-checking bench for vfclass_seq: directed vector table, stall/reset sequences, random vs. model.
module tb_vfclass_seq;
    localparam int unsigned N   = 4;
    localparam int unsigned TW  = 5;
    localparam int unsigned VLW = 3;
    localparam int unsigned DW  = N * 64;

    logic            clk = 1'b0;
    logic            rstn = 1'b1;
    logic            req_valid = 1'b0;
    logic            req_ready;
    logic [DW-1:0]   req_data = '0;
    logic [N-1:0]    req_mask = '0;
    logic [VLW-1:0]  req_vl = '0;
    logic [TW-1:0]   req_tag = '0;
    logic            resp_valid;
    logic            resp_ready = 1'b0;
    logic [DW-1:0]   resp_data;
    logic [TW-1:0]   resp_tag;
    logic            busy;
`ifdef VFCLASS_SEQ_NAN_CNT_EN
    logic [31:0]     nan_cnt;
`endif

    int checks   = 0;
    int failures = 0;
    int nan_total = 0;

    vfclass_seq #(.NUM_ELEM(N), .TAG_W(TW)) dut (
        .clk_i        (clk),
        .rstn_i       (rstn),
        .req_valid_i  (req_valid),
        .req_ready_o  (req_ready),
        .req_data_i   (req_data),
        .req_mask_i   (req_mask),
        .req_vl_i     (req_vl),
        .req_tag_i    (req_tag),
        .resp_valid_o (resp_valid),
        .resp_ready_i (resp_ready),
        .resp_data_o  (resp_data),
        .resp_tag_o   (resp_tag),
        .busy_o       (busy)
`ifdef VFCLASS_SEQ_NAN_CNT_EN
        ,
        .nan_cnt_o    (nan_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", nm, got, exp);
        end
    endtask

    // Reference: fclass from IEEE-754 field rules.
    function automatic logic [63:0] model_fclass(input logic [63:0] x);
        logic        neg;
        int unsigned e;
        logic [51:0] m;
        neg = x[63];
        e   = int'(x[62:52]);
        m   = x[51:0];
        if (e == 2047 && m != 0) return (m >= 52'h8_0000_0000_0000) ? 64'h200 : 64'h100;
        if (e == 2047)           return neg ? 64'h1 : 64'h80;
        if (e == 0 && m == 0)    return neg ? 64'h8 : 64'h10;
        if (e == 0)              return neg ? 64'h4 : 64'h20;
        return neg ? 64'h2 : 64'h40;
    endfunction

    function automatic logic [DW-1:0] model_resp(input logic [DW-1:0] d, input logic [N-1:0] m,
                                                 input logic [VLW-1:0] v);
        logic [DW-1:0] r;
        logic [63:0]   e;
        int            lim;
        lim = (int'(v) > N) ? N : int'(v);
        for (int k = 0; k < N; k++) begin
            e = d[k*64 +: 64];
            r[k*64 +: 64] = (k < lim && m[k]) ? model_fclass(e) : 64'hFFFF_FFFF_FFFF_FFFF;
        end
        return r;
    endfunction

    function automatic int model_nans(input logic [DW-1:0] d, input logic [N-1:0] m,
                                      input logic [VLW-1:0] v);
        int          n;
        int          lim;
        logic [63:0] f;
        n = 0;
        lim = (int'(v) > N) ? N : int'(v);
        for (int k = 0; k < N; k++) begin
            f = model_fclass(d[k*64 +: 64]);
            if (k < lim && m[k] && f >= 64'h100) n++;
        end
        return n;
    endfunction

    function automatic logic [63:0] rand_elem();
        logic [10:0] e;
        logic [51:0] m;
        case ($urandom_range(0, 3))
            0:       e = 11'h000;
            1:       e = 11'h7FF;
            default: e = 11'($urandom_range(1, 2046));
        endcase
        case ($urandom_range(0, 3))
            0:       m = '0;
            1:       m = {1'b1, 51'($urandom)};
            2:       m = {1'b0, 19'($urandom), 32'($urandom) | 32'h1};
            default: m = {20'($urandom), 32'($urandom)};
        endcase
        return {1'($urandom), e, m};
    endfunction

    // Issue one request, wait for response, optionally stall, then handshake.
    task automatic run_txn(input logic [DW-1:0] d, input logic [N-1:0] m, input logic [VLW-1:0] v,
                           input logic [TW-1:0] t, input int hold, input logic stall_chk,
                           output logic [DW-1:0] got, output logic [TW-1:0] gtag, output int lat);
        logic stable;
        @(negedge clk);
        req_valid = 1'b1;
        req_data  = d;
        req_mask  = m;
        req_vl    = v;
        req_tag   = t;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("busy_in_run", DW'({busy, req_ready}), DW'(2'b10));
        lat = 0;
        while (!resp_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        got    = resp_data;
        gtag   = resp_tag;
        stable = 1'b1;
        for (int i = 0; i < hold; i++) begin
            if (stall_chk) begin
                req_valid = 1'b1;
                req_data  = ~d;
                req_tag   = ~t;
            end
            @(posedge clk);
            #1;
            if (!resp_valid || resp_data !== got || resp_tag !== gtag || req_ready || !busy)
                stable = 1'b0;
        end
        req_valid = 1'b0;
        if (stall_chk) chk("stall_stable", DW'(stable), DW'(1'b1));
        @(negedge clk);
        resp_ready = 1'b1;
        @(posedge clk);
        #1;
        resp_ready = 1'b0;
        chk("post_handshake", DW'({req_ready, resp_valid, busy}), DW'(3'b100));
    endtask

    typedef struct {
        logic [DW-1:0]  data;
        logic [N-1:0]   mask;
        logic [VLW-1:0] vl;
        logic [DW-1:0]  exp;
        int             nans;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic [DW-1:0] got;
        logic [DW-1:0] d;
        logic [TW-1:0] gtag;
        logic [TW-1:0] t;
        logic [N-1:0]  m;
        logic [VLW-1:0] v;
        int            lat;
        int            hold;

        vecs[0] = '{ {64'h000F_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, 64'hFFF0_0000_0000_0000, 64'h3FF0_0000_0000_0000},
                     4'hF, 3'd4, {64'h20, 64'h08, 64'h01, 64'h40}, 0 };
        vecs[1] = '{ {64'h3FF0_0000_0000_0000, 64'h0, 64'hFFF0_0000_0000_0001, 64'h7FF8_0000_0000_0000},
                     4'hF, 3'd2, {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h100, 64'h200}, 2 };
        vecs[2] = '{ {64'h7FF8_0000_0000_0000, 64'h4000_0000_0000_0000, 64'h0, 64'hBFF0_0000_0000_0000},
                     4'b1010, 3'd3, {64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hFFFF_FFFF_FFFF_FFFF}, 0 };
        vecs[3] = '{ {64'h0010_0000_0000_0000, 64'hC000_0000_0000_0000, 64'h8000_0000_0000_0001, 64'h7FF0_0000_0000_0000},
                     4'hF, 3'd7, {64'h40, 64'h02, 64'h04, 64'h80}, 0 };
        vecs[4] = '{ {64'h7FF8_0000_0000_0000, 64'h7FF8_0000_0000_0000, 64'h7FF8_0000_0000_0000, 64'h7FF8_0000_0000_0000},
                     4'hF, 3'd0, {DW{1'b1}}, 0 };

        #2 rstn = 1'b0;
        #1;
        chk("rst_outputs", DW'({req_ready, resp_valid, busy}), DW'(3'b100));
        chk("rst_data", resp_data, '0);
        chk("rst_tag", DW'(resp_tag), '0);
`ifdef VFCLASS_SEQ_NAN_CNT_EN
        chk("rst_nan_cnt", DW'(nan_cnt), '0);
`endif
        #20;
        @(negedge clk);
        rstn = 1'b1;

        for (int i = 0; i < 5; i++) begin
            t = TW'(i + 3);
            run_txn(vecs[i].data, vecs[i].mask, vecs[i].vl, t, 0, 1'b0, got, gtag, lat);
            nan_total += vecs[i].nans;
            chk($sformatf("vec%0d_data", i), got, vecs[i].exp);
            chk($sformatf("vec%0d_tag", i), DW'(gtag), DW'(t));
            chk($sformatf("vec%0d_latency", i), DW'(lat), DW'(5));
`ifdef VFCLASS_SEQ_NAN_CNT_EN
            chk($sformatf("vec%0d_nan_cnt", i), DW'(nan_cnt), DW'(nan_total));
`endif
        end

        // Response held for 10 cycles while a competing request is presented.
        run_txn(vecs[0].data, vecs[0].mask, vecs[0].vl, 5'h1A, 10, 1'b1, got, gtag, lat);
        chk("stall_data", got, vecs[0].exp);
        chk("stall_tag", DW'(gtag), DW'(5'h1A));
        chk("stall_no_accept", DW'({busy, resp_valid}), DW'(2'b00));

        // Asynchronous reset while element index 2 is being processed.
        @(negedge clk);
        req_valid = 1'b1;
        req_data  = vecs[1].data;
        req_mask  = 4'hF;
        req_vl    = 3'd4;
        req_tag   = 5'h07;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rstn = 1'b0;
        #1;
        chk("midrun_rst", DW'({req_ready, resp_valid, busy}), DW'(3'b100));
        chk("midrun_rst_data", resp_data, '0);
        nan_total = 0;
`ifdef VFCLASS_SEQ_NAN_CNT_EN
        chk("midrun_rst_nan", DW'(nan_cnt), '0);
`endif
        @(negedge clk);
        rstn = 1'b1;
        run_txn(vecs[3].data, vecs[3].mask, vecs[3].vl, 5'h11, 1, 1'b0, got, gtag, lat);
        chk("after_rst_data", got, vecs[3].exp);
        chk("after_rst_tag", DW'(gtag), DW'(5'h11));
        chk("after_rst_latency", DW'(lat), DW'(5));

        // Randomized traffic against the reference model.
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < N; k++) d[k*64 +: 64] = rand_elem();
            m    = N'($urandom);
            v    = VLW'($urandom_range(0, 7));
            t    = TW'($urandom);
            hold = $urandom_range(0, 3);
            run_txn(d, m, v, t, hold, 1'b0, got, gtag, lat);
            nan_total += model_nans(d, m, v);
            chk($sformatf("rand%0d_data", r), got, model_resp(d, m, v));
            chk($sformatf("rand%0d_tag", r), DW'(gtag), DW'(t));
            chk($sformatf("rand%0d_latency", r), DW'(lat), DW'(5));
`ifdef VFCLASS_SEQ_NAN_CNT_EN
            chk($sformatf("rand%0d_nan_cnt", r), DW'(nan_cnt), DW'(nan_total));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/vfclass_seq.md
VFCLASS_SEQ -- requirements
Module: vfclass_seq

Interface
REQ-001 SHALL have parameter NUM_ELEM, default 4, meaning 64-bit elements per request (power of two, 2..16).
REQ-002 SHALL have parameter TAG_W, default 5, meaning width of the request tag returned with the response.
REQ-003 SHALL have port clk_i  input  1  sole clock; all state on rising edge.
REQ-004 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port req_valid_i  input  1  request valid.
REQ-006 SHALL have port req_ready_o  output  1  block can accept a request.
REQ-007 SHALL have port req_data_i  input  NUM_ELEM*64  source elements; element k at bits [64k+63:64k], fp_t layout.
REQ-008 SHALL have port req_mask_i  input  NUM_ELEM  per-element active mask.
REQ-009 SHALL have port req_vl_i  input  $clog2(NUM_ELEM)+1  active vector length.
REQ-010 SHALL have port req_tag_i  input  TAG_W  request tag.
REQ-011 SHALL have port resp_valid_o  output  1  response valid.
REQ-012 SHALL have port resp_ready_i  input  1  consumer accepts response.
REQ-013 SHALL have port resp_data_o  output  NUM_ELEM*64  per-element fclass results.
REQ-014 SHALL have port resp_tag_o  output  TAG_W  tag of the response.
REQ-015 SHALL have port busy_o  output  1  high in any state other than IDLE.

Function
REQ-016 SHALL implement FSM IDLE, RUN, DONE; req_ready_o is high only in IDLE.
REQ-017 SHALL, on req_valid_i & req_ready_o, capture data, mask, vl and tag, clear the element index to 0, and go to RUN.
REQ-018 SHALL, in RUN, process exactly one element per cycle, in index order 0..NUM_ELEM-1, using one classifier_DFP instance fed from the captured element at the current index.
REQ-019 SHALL treat element k as active iff k < vl and mask[k]=1.
REQ-020 SHALL write each active result as the RISC-V fclass mask, zero-extended to 64 bits: bit0 -inf, bit1 -normal, bit2 -subnormal, bit3 -0, bit4 +0, bit5 +subnormal, bit6 +normal, bit7 +inf, bit8 sNaN, bit9 qNaN.
REQ-021 SHALL, for NaN inputs, ignore the sign-based QNAN/SNAN split of fp_class_t and select qNaN when mantissa bit 51 is 1, sNaN when it is 0.
REQ-022 SHALL write all-ones (64'hFFFF_FFFF_FFFF_FFFF) for every inactive element (mask/tail agnostic).
REQ-023 SHALL leave RUN for DONE in the cycle after element NUM_ELEM-1 is written; request-accept to resp_valid_o latency is therefore NUM_ELEM+1 cycles, independent of vl.
REQ-024 SHALL, in DONE, hold resp_valid_o high with resp_data_o and resp_tag_o stable until resp_ready_i; on handshake, return to IDLE.
REQ-025 SHALL NOT assert req_ready_o in the handshake cycle (no back-to-back overlap); the next request is accepted at earliest one cycle after the response handshake.
REQ-026 SHALL treat vl=0 as all elements inactive; vl values above NUM_ELEM SHALL saturate to NUM_ELEM.
REQ-027 SHALL ignore req_valid_i while not in IDLE and SHALL ignore resp_ready_i while not in DONE.

Reset
REQ-028 SHALL, on rstn_i low at any time, including mid-RUN or in DONE, asynchronously return to IDLE and drop any in-flight request.
REQ-029 SHALL reset outputs to: req_ready_o=1, resp_valid_o=0, busy_o=0, resp_data_o=0, resp_tag_o=0.
REQ-030 SHALL accept a request in the first rising edge after rstn_i deasserts.

Configuration
REQ-031 SHALL, when macro VFCLASS_SEQ_NAN_CNT_EN is defined, add output nan_cnt_o (32 bits), which counts active elements classified as sNaN or qNaN, saturates at 32'hFFFF_FFFF, and resets to 0.
REQ-032 SHALL, when VFCLASS_SEQ_NAN_CNT_EN is undefined, omit nan_cnt_o and its counter; all other behaviour is identical.

Verification
REQ-033 SHALL cover: NUM_ELEM=4, vl=4, mask=4'hF, elements {3FF0000000000000, FFF0000000000000, 8000000000000000, 000FFFFFFFFFFFFF} -> results {0x40, 0x01, 0x08, 0x20}; resp_valid_o rises 5 cycles after accept.
REQ-034 SHALL cover: NaN elements 7FF8000000000000, FFF0000000000001, vl=2 -> results 0x200, 0x100, then all-ones, all-ones; nan_cnt_o +2 when enabled.
REQ-035 SHALL cover: vl=3, mask=4'b1010 -> elem0, elem2 and elem3 all-ones; elem1 classified; latency still 5 cycles.
REQ-036 SHALL cover: resp_ready_i held low 10 cycles in DONE -> resp_valid_o and resp_data_o stable, req_ready_o low, new req_valid_i ignored.
REQ-037 SHALL cover: rstn_i pulsed low during RUN at element index 2 -> immediate IDLE, resp_valid_o=0, req_ready_o=1; the next request completes correctly.
